booth_mult_seq16: RTL and testbench

//  Sequential 16x16 signed multiplier, radix-2 Booth, one add/sub step per clock.

---
 rtl/booth_mult_seq16.sv | 174 +++++++++++++++++
 tb/tb_booth_mult_seq16.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq16.sv
// ---------------------------------------------------------------------------
// booth_mult_seq16 : sequential 16x16 signed multiplier, radix-2 Booth.
//   One add/sub step per clock through a single 16-bit carry-lookahead adder
//   (cla16, below). A start pulse latches the operands. Sixteen RUN cycles
//   follow, then one DONE cycle that presents the product with a RDY pulse.
//
// Ports
//   clock           in   rising-edge clock
//   resetn          in   asynchronous active-low reset
//   ctrl_MULT       in   start pulse; operands sampled on the same edge
//   data_operandA   in   multiplicand M (two's complement)
//   data_operandB   in   multiplier Q (two's complement)
//   data_result     out  signed product {A,Q}; holds until the next start
//   data_resultRDY  out  one-cycle pulse in the DONE cycle
//   data_exception  out  product does not fit in 16 bits signed (with RDY)
//   busy            out  high while iterating (RUN)
//
// Configuration macro
//   MULT_RESTART_WHILE_BUSY_EN : if defined, ctrl_MULT during RUN aborts the
//   current op and restarts with fresh operands. Otherwise it is ignored.
// ---------------------------------------------------------------------------

// 16-bit carry-lookahead adder: 4-bit groups, lookahead inside each group and
// across the groups.
module cla16 (
   input  logic [15:0] i_a,
   input  logic [15:0] i_b,
   input  logic        i_cin,
   output logic [15:0] o_sum
);
   logic [15:0] w_g, w_p, w_c;
   logic [2:0]  w_gg, w_gp;   // the top group's generate/propagate would only feed carry-out
   logic [3:0]  w_cg;         // carry into each 4-bit group

   assign w_g = i_a & i_b;
   assign w_p = i_a ^ i_b;

   genvar j;
   generate
      for (j = 0; j < 4; j++) begin : g_grp
         if (j < 3) begin : g_gp
            assign w_gg[j] = w_g[4*j+3]
                           | (w_p[4*j+3] & w_g[4*j+2])
                           | (w_p[4*j+3] & w_p[4*j+2] & w_g[4*j+1])
                           | (w_p[4*j+3] & w_p[4*j+2] & w_p[4*j+1] & w_g[4*j]);
            assign w_gp[j] = &w_p[4*j+3 -: 4];
         end
         assign w_c[4*j]   = w_cg[j];
         assign w_c[4*j+1] = w_g[4*j] | (w_p[4*j] & w_cg[j]);
         assign w_c[4*j+2] = w_g[4*j+1] | (w_p[4*j+1] & w_g[4*j])
                           | (w_p[4*j+1] & w_p[4*j] & w_cg[j]);
         assign w_c[4*j+3] = w_g[4*j+2] | (w_p[4*j+2] & w_g[4*j+1])
                           | (w_p[4*j+2] & w_p[4*j+1] & w_g[4*j])
                           | (w_p[4*j+2] & w_p[4*j+1] & w_p[4*j] & w_cg[j]);
      end
   endgenerate

   assign w_cg[0] = i_cin;
   assign w_cg[1] = w_gg[0] | (w_gp[0] & i_cin);
   assign w_cg[2] = w_gg[1] | (w_gp[1] & w_gg[0]) | (w_gp[1] & w_gp[0] & i_cin);
   assign w_cg[3] = w_gg[2] | (w_gp[2] & w_gg[1]) | (w_gp[2] & w_gp[1] & w_gg[0])
                  | (w_gp[2] & w_gp[1] & w_gp[0] & i_cin);

   assign o_sum = w_p ^ w_c;
endmodule

module booth_mult_seq16 #(
   parameter int WIDTH = 16,   // tied to the 16-bit adder; other values unsupported
   parameter int CNT_W = 5     // 2**CNT_W > WIDTH
) (
   input  logic                 clock,
   input  logic                 resetn,
   input  logic                 ctrl_MULT,
   input  logic [WIDTH-1:0]     data_operandA,
   input  logic [WIDTH-1:0]     data_operandB,
   output logic [2*WIDTH-1:0]   data_result,
   output logic                 data_resultRDY,
   output logic                 data_exception,
   output logic                 busy
);
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   state_t             r_state, w_state_nxt;
   logic [WIDTH-1:0]   r_A, r_Q, r_M;
   logic               r_Q1;
   logic [CNT_W-1:0]   r_cnt;

   logic               w_start, w_last;
   logic [WIDTH-1:0]   w_add_b, w_sum;
   logic               w_cin, w_ov, w_ts, w_hi_eq;

   // Start is accepted in IDLE and DONE. RUN accepts it only with restart enabled.
`ifdef MULT_RESTART_WHILE_BUSY_EN
   assign w_start = ctrl_MULT;
`else
   assign w_start = ctrl_MULT & (r_state != S_RUN);
`endif

   assign w_last = (r_cnt == CNT_W'(WIDTH-1));

   // Booth recoding on {Q[0],Q_1}. Subtraction is done as A + ~M + 1.
   always_comb begin
      w_add_b = '0;
      w_cin   = 1'b0;
      case ({r_Q[0], r_Q1})
         2'b01:   w_add_b = r_M;
         2'b10: begin
            w_add_b = ~r_M;
            w_cin   = 1'b1;
         end
         default: w_add_b = '0;
      endcase
   end

   cla16 u_cla (
      .i_a   (r_A),
      .i_b   (w_add_b),
      .i_cin (w_cin),
      .o_sum (w_sum)
   );

   // On signed overflow the sum's MSB is the wrong sign. Flipping it gives the
   // true 17th-bit sign for the arithmetic shift. This matters when M = 0x8000,
   // because ~M + 1 wraps.
   assign w_ov = (r_A[WIDTH-1] == w_add_b[WIDTH-1]) & (w_sum[WIDTH-1] != r_A[WIDTH-1]);
   assign w_ts = w_sum[WIDTH-1] ^ w_ov;

   // Next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_start) w_state_nxt = S_RUN;
         S_RUN: begin
            if (w_start)     w_state_nxt = S_RUN;
            else if (w_last) w_state_nxt = S_DONE;
         end
         S_DONE:  w_state_nxt = w_start ? S_RUN : S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // Datapath.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_A   <= '0;
         r_Q   <= '0;
         r_M   <= '0;
         r_Q1  <= 1'b0;
         r_cnt <= '0;
      end else if (w_start) begin
         r_A   <= '0;
         r_Q   <= data_operandB;
         r_M   <= data_operandA;
         r_Q1  <= 1'b0;
         r_cnt <= '0;
      end else if (r_state == S_RUN) begin
         {r_A, r_Q, r_Q1} <= {w_ts, w_sum, r_Q};
         r_cnt            <= r_cnt + 1'b1;
      end
   end

   // The product fits in WIDTH bits only if A and Q's MSB are all copies of one sign bit.
   assign w_hi_eq = (&{r_A, r_Q[WIDTH-1]}) | ~(|{r_A, r_Q[WIDTH-1]});

   assign data_result    = {r_A, r_Q};
   assign data_resultRDY = (r_state == S_DONE);
   assign data_exception = (r_state == S_DONE) & ~w_hi_eq;
   assign busy           = (r_state == S_RUN);
endmodule

// File: tb/tb_booth_mult_seq16.sv
module tb_booth_mult_seq16;
   logic        clock = 1'b0;
   logic        resetn;
   logic        ctrl_MULT;
   logic [15:0] data_operandA, data_operandB;
   logic [31:0] data_result;
   logic        data_resultRDY, data_exception, busy;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] res;
      logic        exc;
   } exp_t;
   exp_t sb[$];

   booth_mult_seq16 dut (
      .clock          (clock),
      .resetn         (resetn),
      .ctrl_MULT      (ctrl_MULT),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_resultRDY (data_resultRDY),
      .data_exception (data_exception),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t e;
      logic signed [31:0] p;
      p     = $signed(a) * $signed(b);
      e.res = p;
      e.exc = !((&p[31:15]) || !(|p[31:15]));
      return e;
   endfunction

   task automatic push_exp(input logic [15:0] a, input logic [15:0] b);
      sb.push_back(model(a, b));
   endtask

   // Called #1 after an edge. Drives a start that the next edge samples. Returns
   // #1 after that edge (RUN cycle 1) with the operands scrambled.
   task automatic start_op(input logic [15:0] a, input logic [15:0] b, input bit push);
      data_operandA = a;
      data_operandB = b;
      ctrl_MULT     = 1'b1;
      if (push) push_exp(a, b);
      @(posedge clock); #1;
      ctrl_MULT     = 1'b0;
      data_operandA = 16'($urandom);
      data_operandB = 16'($urandom);
   endtask

   // Waits for RDY, counting edges after the start edge. RDY must occupy the
   // 17th cycle after the start edge, i.e. first visible after 16 edges.
   // Pops the scoreboard on RDY and checks it.
   task automatic wait_rdy(input string nm, input int exp_lat);
      int   lat;
      exp_t e;
      lat = 0;
      for (int k = 1; k <= 40 && lat == 0; k++) begin
         @(posedge clock); #1;
         if (data_resultRDY) lat = k;
      end
      total++;
      if (lat == 0) begin
         bad++;
         $display("FAIL %s_rdy: no RDY within 40 cycles, required at %0d", nm, exp_lat);
      end else if (lat != exp_lat) begin
         bad++;
         $display("FAIL %s_latency: got %0d cycles, required %0d", nm, lat, exp_lat);
      end
      if (lat != 0) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL %s_sb: RDY with empty scoreboard, result=%h", nm, data_result);
         end else begin
            e = sb.pop_front();
            if (data_result !== e.res) begin
               bad++;
               $display("FAIL %s_result: got %h, required %h", nm, data_result, e.res);
            end
            total++;
            if (data_exception !== e.exc) begin
               bad++;
               $display("FAIL %s_exc: got %b, required %b", nm, data_exception, e.exc);
            end
            total++;
            if (busy !== 1'b0) begin
               bad++;
               $display("FAIL %s_busy_done: got %b, required 0", nm, busy);
            end
         end
      end
   endtask

   task automatic test_reset();
      resetn = 1'b0; ctrl_MULT = 1'b0; data_operandA = '0; data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      total++;
      if ({data_result, data_resultRDY, data_exception, busy} !== 35'd0) begin
         bad++;
         $display("FAIL reset_outputs: got res=%h rdy=%b exc=%b busy=%b, required all 0",
                  data_result, data_resultRDY, data_exception, busy);
      end
      resetn = 1'b1;
      @(posedge clock); #1;
   endtask

   task automatic test_vectors();
      logic [15:0] va[6] = '{16'd3, 16'hFFF9, 16'h8000, 16'h7FFF, 16'h0100, 16'h0000};
      logic [15:0] vb[6] = '{16'd5, 16'h0006, 16'h8000, 16'hFFFF, 16'h0100, 16'h1234};
      logic [31:0] vr[6] = '{32'h0000000F, 32'hFFFFFFD6, 32'h40000000,
                             32'hFFFF8001, 32'h00010000, 32'h00000000};
      logic        ve[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      for (int i = 0; i < 6; i++) begin
         // Cross-check the model against the hand values before trusting it.
         total++;
         if (model(va[i], vb[i]).res !== vr[i] || model(va[i], vb[i]).exc !== ve[i]) begin
            bad++;
            $display("FAIL vec%0d_model: got %h/%b, required %h/%b", i,
                     model(va[i], vb[i]).res, model(va[i], vb[i]).exc, vr[i], ve[i]);
         end
         start_op(va[i], vb[i], 1'b1);
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL vec%0d_busy: got %b, required 1", i, busy);
         end
         wait_rdy($sformatf("vec%0d", i), 16);
         @(posedge clock); #1;
         total++;
         if (data_resultRDY !== 1'b0 || data_result !== vr[i]) begin
            bad++;
            $display("FAIL vec%0d_after: got rdy=%b res=%h, required 0 and %h",
                     i, data_resultRDY, data_result, vr[i]);
         end
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         start_op(16'($urandom), 16'($urandom), 1'b1);
         wait_rdy($sformatf("rand%0d", i), 16);
      end
   endtask

   task automatic test_midrun_reset();
      int pulses;
      start_op(16'd5, 16'd7, 1'b1);
      repeat (7) @(posedge clock);   // now in RUN cycle 8
      #1;
      resetn = 1'b0;
      #1;
      total++;
      if ({data_result, data_resultRDY, data_exception, busy} !== 35'd0) begin
         bad++;
         $display("FAIL midreset_outputs: got res=%h rdy=%b exc=%b busy=%b, required all 0",
                  data_result, data_resultRDY, data_exception, busy);
      end
      sb.delete();
      pulses = 0;
      repeat (2) @(posedge clock);
      #1;
      resetn = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(posedge clock); #1;
         if (data_resultRDY) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL midreset_rdy: got %0d RDY pulses, required 0", pulses);
      end
      start_op(16'd2, 16'd2, 1'b1);
      wait_rdy("after_reset", 16);
   endtask

   // 9x9 started, then 4x4 driven so that the edge ending RUN cycle 5 samples it.
   task automatic test_restart();
      int pulses;
      start_op(16'd9, 16'd9, 1'b0);
      repeat (4) @(posedge clock);   // now in RUN cycle 5
      #1;
`ifdef MULT_RESTART_WHILE_BUSY_EN
      push_exp(16'd4, 16'd4);
      start_op(16'd4, 16'd4, 1'b0);
      wait_rdy("restart", 16);
`else
      push_exp(16'd9, 16'd9);
      start_op(16'd4, 16'd4, 1'b0);
      wait_rdy("restart", 11);       // still 16 edges after the first start
`endif
      pulses = 0;
      for (int k = 0; k < 25; k++) begin
         @(posedge clock); #1;
         if (data_resultRDY) pulses++;
      end
      total++;
      if (pulses != 0) begin
         bad++;
         $display("FAIL restart_extra_rdy: got %0d further RDY pulses, required 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      start_op(16'd3, 16'd4, 1'b1);
      wait_rdy("b2b_first", 16);
      // Still in the DONE cycle: start the next op here.
      start_op(16'hFFFA, 16'd7, 1'b1);
      wait_rdy("b2b_second", 16);
      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("FAIL b2b_sb_left: got %0d pending, required 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_vectors();
      test_random();
      test_midrun_reset();
      test_restart();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
